// File: rtl/dlfloat_pkg.sv
// Shared types and constants for the DLFloat16 (1/6/9, bias 31) multiplier datapath.
package dlfloat_pkg;

    localparam int BIAS   = 31;
    localparam int EXP_W  = 6;
    localparam int FRAC_W = 9;
    localparam int PROD_W = 2 * (FRAC_W + 1);

    localparam logic [15:0] DLF_ZERO           = 16'h0000;
    localparam logic [14:0] DLF_MAX_FINITE_MAG = 15'h7FFE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } dlf_state_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } dlf_t;

    // Round-to-nearest-even increment decision from guard, sticky and kept LSB.
    function automatic logic rne_round_up(input logic guard, input logic sticky, input logic lsb);
        return guard & (sticky | lsb);
    endfunction

endpackage

// File: rtl/dlfloat_round_pack.sv
// Combinational RNE rounding, exponent range classification and packing of a
// normalized significand (bit 18 is the hidden one).
module dlfloat_round_pack
    import dlfloat_pkg::*;
(
    input  logic               sign,
    input  logic signed [8:0]  e,
    input  logic [PROD_W-1:0]  p,
    input  logic               s,
    output logic [15:0]        result,
    output logic               ovf,
    output logic               unf,
    output logic               inexact
);

    logic [9:0]        mant_s;
    logic              guard_s;
    logic              sticky_s;
    logic [10:0]       sum_s;
    logic [9:0]        mant_rnd_s;
    logic signed [8:0] e_rnd_s;
    dlf_t              packed_s;

    assign mant_s   = p[18:9];
    assign guard_s  = p[8];
    assign sticky_s = (|p[7:0]) | s;
    assign sum_s    = {1'b0, mant_s} + {10'd0, rne_round_up(guard_s, sticky_s, mant_s[0])};

    // Rounding, carry-out renormalization and final classification.
    always_comb begin
        mant_rnd_s = sum_s[9:0];
        e_rnd_s    = e;
        packed_s   = '{sign: sign, exp: 6'd0, frac: 9'd0};
        result     = DLF_ZERO;
        ovf        = 1'b0;
        unf        = 1'b0;
        inexact    = guard_s | sticky_s;

        if (sum_s[10]) begin
            mant_rnd_s = 10'h200;
            e_rnd_s    = e + 9'sd1;
        end else begin
            mant_rnd_s = sum_s[9:0];
            e_rnd_s    = e;
        end

        if (e_rnd_s < 9'sd1) begin
            result = DLF_ZERO;
            unf    = 1'b1;
        end else if ((e_rnd_s > 9'sd63) ||
                     ((e_rnd_s == 9'sd63) && (mant_rnd_s[8:0] == 9'h1FF))) begin
            // The all-ones fraction at the top exponent is reserved for NaN/Inf.
            result = {sign, DLF_MAX_FINITE_MAG};
            ovf    = 1'b1;
        end else begin
            packed_s.exp  = e_rnd_s[5:0];
            packed_s.frac = mant_rnd_s[8:0];
            result        = packed_s;
        end
    end

endmodule

// File: rtl/dlfloat_mul_norm_round.sv
// Normalize/round/pack stage of the DLFloat16 multiplier: one normalization
// bit per cycle, then RNE rounding, with valid/ready on both sides.
module dlfloat_mul_norm_round
    import dlfloat_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [7:0]        in_exp,
    input  logic              in_zero,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_result,
    output logic              out_ovf,
    output logic              out_unf,
    output logic              out_inexact,
    output logic              busy
);

    dlf_state_e        state_r;
    logic              sign_r;
    logic signed [8:0] e_r;
    logic [PROD_W-1:0] p_r;
    logic              s_r;
    logic              in_ready_r;
    logic              busy_r;
    logic              out_valid_r;
    logic [15:0]       out_result_r;
    logic              out_ovf_r;
    logic              out_unf_r;
    logic              out_inexact_r;

    logic [15:0]       rp_result_s;
    logic              rp_ovf_s;
    logic              rp_unf_s;
    logic              rp_inexact_s;

    dlfloat_round_pack u_round_pack (
        .sign    (sign_r),
        .e       (e_r),
        .p       (p_r),
        .s       (s_r),
        .result  (rp_result_s),
        .ovf     (rp_ovf_s),
        .unf     (rp_unf_s),
        .inexact (rp_inexact_s)
    );

    // Control FSM, normalization shifter and registered result/flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            sign_r        <= 1'b0;
            e_r           <= 9'sd0;
            p_r           <= 20'd0;
            s_r           <= 1'b0;
            in_ready_r    <= 1'b1;
            busy_r        <= 1'b0;
            out_valid_r   <= 1'b0;
            out_result_r  <= DLF_ZERO;
            out_ovf_r     <= 1'b0;
            out_unf_r     <= 1'b0;
            out_inexact_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        sign_r        <= in_sign;
                        e_r           <= {in_exp[7], in_exp};
                        p_r           <= in_prod;
                        s_r           <= 1'b0;
                        out_ovf_r     <= 1'b0;
                        out_unf_r     <= 1'b0;
                        out_inexact_r <= 1'b0;
                        in_ready_r    <= 1'b0;
                        busy_r        <= 1'b1;
                        if (in_zero || (in_prod == 20'd0)) begin
                            out_result_r <= DLF_ZERO;
                            out_valid_r  <= 1'b1;
                            state_r      <= DONE;
                        end else begin
                            state_r <= NORM;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                NORM: begin
                    if (p_r[19]) begin
                        p_r <= {1'b0, p_r[19:1]};
                        s_r <= s_r | p_r[0];
                        e_r <= e_r + 9'sd1;
                    end else if (!p_r[18]) begin
                        p_r <= {p_r[18:0], 1'b0};
                        e_r <= e_r - 9'sd1;
                    end else begin
                        state_r <= ROUND;
                    end
                end
                ROUND: begin
                    out_result_r  <= rp_result_s;
                    out_ovf_r     <= rp_ovf_s;
                    out_unf_r     <= rp_unf_s;
                    out_inexact_r <= rp_inexact_s;
                    out_valid_r   <= 1'b1;
                    state_r       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign busy        = busy_r;
    assign out_valid   = out_valid_r;
    assign out_result  = out_result_r;
    assign out_ovf     = out_ovf_r;
    assign out_unf     = out_unf_r;
    assign out_inexact = out_inexact_r;

endmodule
